// File: rtl/mem_access_unit_pkg.sv
// ============================================================================
// Module : mem_access_unit_pkg
// Brief  : Shared state encoding and default sizes for the RAM access unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_access_unit_pkg;

   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_TIMEOUT = 15;
   localparam int BYTE_W      = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module : mem_access_unit
// Brief  : Splits 8/16-bit core loads/stores into byte RAM transactions.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_wide,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [15:0]       req_wdata,
   output logic              rsp_valid,
   output logic [15:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BYTE_W-1:0] mem_wdata,
   input  logic [BYTE_W-1:0] mem_rdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic              mem_ready_r,
   input  logic              mem_ready_w
);

   localparam int c_TMR_W = $clog2(TIMEOUT + 1);

   state_t              r_state,     w_state;
   logic                r_write,     w_write;
   logic                r_wide,      w_wide;
   logic                r_idx,       w_idx;
   logic [ADDR_W-1:0]   r_addr,      w_addr;
   logic [BYTE_W-1:0]   r_wdata_hi,  w_wdata_hi;
   logic [BYTE_W-1:0]   r_mem_wdata, w_mem_wdata;
   logic [15:0]         r_rdata,     w_rdata;
   logic                r_err,       w_err;
   logic [c_TMR_W-1:0]  r_timer,     w_timer;
   logic                r_req_ready, w_req_ready;
   logic                r_rsp_valid, w_rsp_valid;
   logic                r_mem_read,  w_mem_read;
   logic                r_mem_write, w_mem_write;
   logic                w_match;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_write     <= 1'b0;
         r_wide      <= 1'b0;
         r_idx       <= 1'b0;
         r_addr      <= '0;
         r_wdata_hi  <= '0;
         r_mem_wdata <= '0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
         r_timer     <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_write     <= w_write;
         r_wide      <= w_wide;
         r_idx       <= w_idx;
         r_addr      <= w_addr;
         r_wdata_hi  <= w_wdata_hi;
         r_mem_wdata <= w_mem_wdata;
         r_rdata     <= w_rdata;
         r_err       <= w_err;
         r_timer     <= w_timer;
         r_req_ready <= w_req_ready;
         r_rsp_valid <= w_rsp_valid;
         r_mem_read  <= w_mem_read;
         r_mem_write <= w_mem_write;
      end
   end

   // Outputs are registered, so strobes are computed for the state being entered.
   always_comb begin
      w_state     = r_state;
      w_write     = r_write;
      w_wide      = r_wide;
      w_idx       = r_idx;
      w_addr      = r_addr;
      w_wdata_hi  = r_wdata_hi;
      w_mem_wdata = r_mem_wdata;
      w_rdata     = r_rdata;
      w_err       = r_err;
      w_timer     = r_timer;
      w_rsp_valid = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_match     = r_write ? mem_ready_w : mem_ready_r;

      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_write     = req_write;
               w_wide      = req_wide;
               w_addr      = req_addr;
               w_wdata_hi  = req_wdata[15:8];
               w_mem_wdata = req_wdata[7:0];
               w_idx       = 1'b0;
               w_rdata     = '0;
               w_err       = 1'b0;
               w_mem_read  = ~req_write;
               w_mem_write = req_write;
               w_state     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_timer = '0;
            w_state = ST_WAIT;
         end
         ST_WAIT: begin
            if (w_match) begin
               if (!r_write) begin
                  if (r_idx) w_rdata[15:8] = mem_rdata;
                  else       w_rdata[7:0]  = mem_rdata;
               end
               if (r_wide && !r_idx) begin
                  w_idx       = 1'b1;
                  w_addr      = r_addr + 1'b1;
                  w_mem_wdata = r_wdata_hi;
                  w_mem_read  = ~r_write;
                  w_mem_write = r_write;
                  w_state     = ST_ISSUE;
               end else begin
                  w_rsp_valid = 1'b1;
                  w_state     = ST_RESP;
               end
            end else if (r_timer == c_TMR_W'(TIMEOUT - 1)) begin
               w_err       = 1'b1;
               w_rsp_valid = 1'b1;
               w_state     = ST_RESP;
            end else begin
               w_timer = r_timer + 1'b1;
            end
         end
         ST_RESP: begin
            w_state = ST_IDLE;
         end
         default: begin
            w_state = ST_IDLE;
         end
      endcase

      w_req_ready = (w_state == ST_IDLE);
   end

   assign req_ready   = r_req_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rdata;
   assign rsp_err     = r_err;
   assign mem_address = r_addr;
   assign mem_wdata   = r_mem_wdata;
   assign mem_read    = r_mem_read;
   assign mem_write   = r_mem_write;

endmodule

`default_nettype wire
